fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined core.
- Owns the program counter, next-PC selection (sequential, branch redirect, hold) and the IF/ID pipeline register.
- Drives the combinational instruction ROM address and presents the latched instruction, PC+4 and a valid bit to the decode stage / control unit.
- Accepts stall from hazard logic and branch redirect from decode, and keeps saturating fetch/flush counters for debug.

---
 rtl/fetch_stage_pkg.sv | 10 +
 rtl/sat_counter.sv | 16 +
 rtl/fetch_stage.sv | 62 ++++++
 tb/tb_fetch_stage.sv | 126 ++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: pipeline constants and fetch FSM encoding shared by the fetch stage
package fetch_stage_pkg;
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_RESET     = 32'h0000_0000;
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        REDIR = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            count <= '0;
        else
            count <= clear ? '0 : (inc && count != '1) ? count + CNT_W'(1) : count;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, next-PC selection and IF/ID register with saturating debug counters
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int          IMEM_AW  = 8,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF,
    parameter int          CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    output logic [31:0]        pc,
    output logic [31:0]        ifid_instr,
    output logic [31:0]        ifid_pc_plus4,
    output logic               ifid_valid,
    output logic [CNT_W-1:0]   fetch_count,
    output logic [CNT_W-1:0]   flush_count
);
    fetch_state_t state;
    logic [31:0]  pc_plus4;
    logic         fetch_en, flush_en;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc[IMEM_AW-1:0];
    // Branches are honoured only in RUN; BOOT and the REDIR bubble always fetch.
    assign flush_en  = state == RUN && !stall && branch_taken;
    assign fetch_en  = state == BOOT || (!stall && !(state == RUN && branch_taken));

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state         <= BOOT;
            pc            <= PC_RESET;
            ifid_instr    <= NOP_WORD;
            ifid_pc_plus4 <= '0;
            ifid_valid    <= 1'b0;
        end else begin
            state <= flush_en ? REDIR : fetch_en ? RUN : state;
            if (fetch_en) begin
                pc            <= pc_plus4;
                ifid_instr    <= imem_data;
                ifid_pc_plus4 <= pc_plus4;
                ifid_valid    <= 1'b1;
            end else if (flush_en) begin
                pc            <= branch_target & ~32'h3;
                ifid_instr    <= NOP_WORD;
                ifid_pc_plus4 <= '0;
                ifid_valid    <= 1'b0;
            end
        end

    sat_counter #(.CNT_W(CNT_W)) u_fetch_cnt (
        .clk(clk), .reset(reset), .inc(fetch_en), .clear(1'b0), .count(fetch_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk(clk), .reset(reset), .inc(flush_en), .clear(1'b0), .count(flush_count)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against hand-computed values
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc, ifid_instr, ifid_pc_plus4;
    logic        ifid_valid;
    logic [15:0] fetch_count, flush_count;
    logic [31:0] rom [64];
    int          checks = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    assign imem_data = rom[imem_addr[7:2]];

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr), .imem_data(imem_data),
        .pc(pc), .ifid_instr(ifid_instr), .ifid_pc_plus4(ifid_pc_plus4),
        .ifid_valid(ifid_valid), .fetch_count(fetch_count), .flush_count(flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_if(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                          input logic [31:0] e_pp4, input logic e_valid,
                          input logic [15:0] e_fc, input logic [15:0] e_flc);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".instr"}, ifid_instr, e_instr);
        chk({tag, ".pc_plus4"}, ifid_pc_plus4, e_pp4);
        chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, e_valid});
        chk({tag, ".fetch_count"}, {16'd0, fetch_count}, {16'd0, e_fc});
        chk({tag, ".flush_count"}, {16'd0, flush_count}, {16'd0, e_flc});
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 | i;
        rom[0] = 32'hE3A0_0001;
        rom[1] = 32'hE281_1002;

        #12;
        chk_if("reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0);
        chk("reset.imem_addr", {24'd0, imem_addr}, 32'h0);
        reset = 1'b1;

        step();
        chk_if("boot", 32'h4, 32'hE3A0_0001, 32'h4, 1'b1, 16'd1, 16'd0);
        chk("boot.imem_addr", {24'd0, imem_addr}, 32'h4);
        step();
        chk_if("run1", 32'h8, 32'hE281_1002, 32'h8, 1'b1, 16'd2, 16'd0);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_if("stall", 32'h8, 32'hE281_1002, 32'h8, 1'b1, 16'd2, 16'd0);
        end
        stall = 1'b0;
        step();
        chk_if("resume", 32'hC, 32'hA000_0002, 32'hC, 1'b1, 16'd3, 16'd0);

        branch_taken = 1'b1;
        branch_target = 32'h22;
        step();
        chk_if("branch", 32'h20, 32'h0, 32'h0, 1'b0, 16'd3, 16'd1);
        chk("branch.imem_addr", {24'd0, imem_addr}, 32'h20);
        branch_target = 32'h40;
        step();
        chk_if("redir", 32'h24, 32'hA000_0008, 32'h24, 1'b1, 16'd4, 16'd1);

        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h10;
        step();
        chk_if("stall_br", 32'h24, 32'hA000_0008, 32'h24, 1'b1, 16'd4, 16'd1);
        stall = 1'b0;
        step();
        chk_if("br2", 32'h10, 32'h0, 32'h0, 1'b0, 16'd4, 16'd2);

        branch_taken = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk_if("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0);
        chk("async_rst.imem_addr", {24'd0, imem_addr}, 32'h0);
        branch_taken = 1'b1;
        branch_target = 32'h30;
        reset = 1'b1;
        step();
        chk_if("reboot", 32'h4, 32'hE3A0_0001, 32'h4, 1'b1, 16'd1, 16'd0);

        branch_target = 32'hFFFF_FFFE;
        step();
        chk_if("br_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 16'd1, 16'd1);
        chk("br_top.imem_addr", {24'd0, imem_addr}, 32'hFC);
        branch_taken = 1'b0;
        step();
        chk_if("wrap", 32'h0, 32'hA000_003F, 32'h0, 1'b1, 16'd2, 16'd1);
        chk("wrap.imem_addr", {24'd0, imem_addr}, 32'h0);

        for (int i = 0; i < 65540; i++) @(posedge clk);
        #1;
        chk("sat.fetch_count", {16'd0, fetch_count}, 32'hFFFF);
        chk("sat.flush_count", {16'd0, flush_count}, 32'h1);
        step();
        chk("sat_hold.fetch_count", {16'd0, fetch_count}, 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
